// File: rtl/conv_mac_array.sv
// Convolution MAC engine: serialised window stream times a registered weight ROM across
// DSP_NO lanes, followed by bias add, round-to-nearest requantisation, saturation and ReLU.
module conv_mac_array #(
  parameter int unsigned DSP_NO     = 16,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHIN       = 64,
  parameter int unsigned KERNEL_DIM = 3,
  parameter int unsigned N_WINDOWS  = 4096,
  parameter int unsigned FRAC       = 8,
  parameter int unsigned RELU_EN    = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [WIDTH-1:0]                               ifm,
  input  logic                                           ifm_valid,
  output logic                                           ifm_ready,
  output logic [$clog2(CHIN*KERNEL_DIM*KERNEL_DIM)-1:0]  weight_addr,
  input  logic [DSP_NO*WIDTH-1:0]                        kernels,
  input  logic [DSP_NO*2*WIDTH-1:0]                      bias,
  output logic [DSP_NO*WIDTH-1:0]                        ofm,
  output logic                                           ofm_valid,
  input  logic                                           ofm_ready,
  output logic                                           busy,
  output logic                                           layer_end
);

  localparam int unsigned Taps = CHIN * KERNEL_DIM * KERNEL_DIM;
  localparam int unsigned TapW = $clog2(Taps);
  localparam int unsigned WinW = (N_WINDOWS > 1) ? $clog2(N_WINDOWS) : 1;
  localparam int unsigned AccW = 2 * WIDTH + TapW;
  localparam int unsigned SumW = AccW + 2;

  localparam logic signed [SumW-1:0] QMax = {{(SumW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SumW-1:0] QMin = {{(SumW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SumW-1:0] Rnd  = {{(SumW-1){1'b0}}, 1'b1} << (FRAC - 1);

  typedef enum logic [2:0] {StIdle, StAcc, StFlush, StQuant, StOut, StDone} state_e;

  state_e                    state_q, state_d;
  logic [TapW-1:0]           tap_q;
  logic [WinW-1:0]           win_q;
  logic signed [WIDTH-1:0]   pix_q;
  logic                      mac_en_q;
  logic signed [AccW-1:0]    acc_q [DSP_NO];
  logic [DSP_NO*WIDTH-1:0]   ofm_q;
  logic                      ofm_valid_q;

  logic signed [2*WIDTH-1:0] prod_w [DSP_NO];
  logic signed [SumW-1:0]    sum_w  [DSP_NO];
  logic signed [SumW-1:0]    shr_w  [DSP_NO];
  logic [WIDTH-1:0]          q_lane [DSP_NO];

  logic accept, start_go, hs, last_tap, last_win;

  assign ifm_ready   = (state_q == StAcc);
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign layer_end   = (state_q == StDone);
  assign weight_addr = tap_q;
  assign ofm         = ofm_q;
  assign ofm_valid   = ofm_valid_q;

  assign accept   = ifm_valid && ifm_ready;
  assign start_go = start && ((state_q == StIdle) || (state_q == StDone));
  assign hs       = (state_q == StOut) && ofm_ready;
  assign last_tap = (tap_q == TapW'(Taps - 1));
  assign last_win = (win_q == WinW'(N_WINDOWS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StAcc;
      StAcc:          if (accept && last_tap) state_d = StFlush;
      StFlush:        state_d = StQuant;
      StQuant:        state_d = StOut;
      StOut:          if (ofm_ready) state_d = last_win ? StDone : StAcc;
      default:        state_d = StIdle;
    endcase
  end

  // Lane arithmetic: product, then bias + rounding + shift + clamp on the accumulator.
  always_comb begin
    for (int i = 0; i < DSP_NO; i++) begin
      prod_w[i] = $signed({{WIDTH{pix_q[WIDTH-1]}}, pix_q})
                * $signed({{WIDTH{kernels[i*WIDTH+WIDTH-1]}}, kernels[i*WIDTH +: WIDTH]});
      sum_w[i]  = {{2{acc_q[i][AccW-1]}}, acc_q[i]}
                + {{(SumW-2*WIDTH){bias[i*2*WIDTH+2*WIDTH-1]}}, bias[i*2*WIDTH +: 2*WIDTH]}
                + Rnd;
      shr_w[i]  = sum_w[i] >>> FRAC;
      if (shr_w[i] > QMax) begin
        q_lane[i] = QMax[WIDTH-1:0];
      end else if (shr_w[i] < QMin) begin
        q_lane[i] = QMin[WIDTH-1:0];
      end else begin
        q_lane[i] = shr_w[i][WIDTH-1:0];
      end
      if ((RELU_EN != 0) && q_lane[i][WIDTH-1]) q_lane[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      win_q       <= '0;
      pix_q       <= '0;
      mac_en_q    <= 1'b0;
      ofm_q       <= '0;
      ofm_valid_q <= 1'b0;
      for (int i = 0; i < DSP_NO; i++) acc_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      mac_en_q <= accept;
      if (accept) pix_q <= ifm;

      if (start_go) begin
        tap_q <= '0;
      end else if (accept) begin
        tap_q <= last_tap ? '0 : tap_q + TapW'(1);
      end

      if (start_go) begin
        win_q <= '0;
      end else if (hs) begin
        win_q <= last_win ? '0 : win_q + WinW'(1);
      end

      // ROM data lags the address by one edge, so the MAC lags the accept by one edge too.
      for (int i = 0; i < DSP_NO; i++) begin
        if (start_go || hs) begin
          acc_q[i] <= '0;
        end else if (mac_en_q) begin
          acc_q[i] <= acc_q[i] + {{(AccW-2*WIDTH){prod_w[i][2*WIDTH-1]}}, prod_w[i]};
        end
      end

      if (state_q == StQuant) begin
        for (int i = 0; i < DSP_NO; i++) ofm_q[i*WIDTH +: WIDTH] <= q_lane[i];
        ofm_valid_q <= 1'b1;
      end else if (hs) begin
        ofm_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_array.sv
// Directed bench for conv_mac_array: a linear single-window instance and a ReLU
// three-window instance share the pixel stream; each has its own registered weight ROM.
module tb_conv_mac_array;

  localparam int Taps = 18;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_l, start_r, ifm_valid, ofm_ready;
  logic [15:0] ifm;
  logic [127:0] bias;
  logic [4:0]  addr_l, addr_r;
  logic [63:0] kern_l, kern_r, ofm_l, ofm_r;
  logic        rdy_l, rdy_r, ov_l, ov_r, busy_l, busy_r, end_l, end_r;

  logic        rom_pat;
  logic [15:0] kval;
  bit          sel;  // 0 = linear DUT, 1 = ReLU DUT

  int total = 0;
  int bad = 0;

  conv_mac_array #(
    .DSP_NO(4), .WIDTH(16), .CHIN(2), .KERNEL_DIM(3), .N_WINDOWS(1), .FRAC(8), .RELU_EN(0)
  ) dut_lin (
    .clk(clk), .rst(rst), .start(start_l), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(rdy_l), .weight_addr(addr_l), .kernels(kern_l), .bias(bias), .ofm(ofm_l),
    .ofm_valid(ov_l), .ofm_ready(ofm_ready), .busy(busy_l), .layer_end(end_l)
  );

  conv_mac_array #(
    .DSP_NO(4), .WIDTH(16), .CHIN(2), .KERNEL_DIM(3), .N_WINDOWS(3), .FRAC(8), .RELU_EN(1)
  ) dut_relu (
    .clk(clk), .rst(rst), .start(start_r), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(rdy_r), .weight_addr(addr_r), .kernels(kern_r), .bias(bias), .ofm(ofm_r),
    .ofm_valid(ov_r), .ofm_ready(ofm_ready), .busy(busy_r), .layer_end(end_r)
  );

  // Pattern ROM: lane i, tap t -> 16*(t+1)*(i+1), so a tap misalignment changes every sum.
  function automatic logic [63:0] rom(input logic [4:0] a);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*16 +: 16] = rom_pat ? 16'((int'(a) + 1) * 16 * (i + 1)) : kval;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    kern_l <= rom(addr_l);
    kern_r <= rom(addr_r);
  end

  wire        cur_rdy  = sel ? rdy_r  : rdy_l;
  wire        cur_ov   = sel ? ov_r   : ov_l;
  wire        cur_busy = sel ? busy_r : busy_l;
  wire        cur_end  = sel ? end_r  : end_l;
  wire [63:0] cur_ofm  = sel ? ofm_r  : ofm_l;
  wire [4:0]  cur_addr = sel ? addr_r : addr_l;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer();
    if (sel) start_r = 1'b1;
    else     start_l = 1'b1;
    tick();
    start_l = 1'b0;
    start_r = 1'b0;
    check_eq("start_ifm_ready", 64'(cur_rdy), 64'd1);
    check_eq("start_busy", 64'(cur_busy), 64'd1);
  endtask

  task automatic push(input logic [15:0] px);
    int n = 0;
    ifm       = px;
    ifm_valid = 1'b1;
    while (!cur_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!cur_rdy) check_eq("push_timeout", 64'(cur_rdy), 64'd1);
    else tick();
    ifm_valid = 1'b0;
  endtask

  // poke is the tap index at which a start pulse is issued mid-window (-1 for none).
  task automatic feed(input logic [15:0] px, input int maxgap, input int poke);
    for (int t = 0; t < Taps; t++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
      if (t == poke) begin
        if (sel) start_r = 1'b1;
        else     start_l = 1'b1;
      end
      push(px);
      start_l = 1'b0;
      start_r = 1'b0;
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!cur_ov && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!cur_ov) check_eq("valid_timeout", 64'(cur_ov), 64'd1);
  endtask

  task automatic take(input string tag, input logic [63:0] exp);
    int c;
    wait_valid(c);
    check_eq(tag, cur_ofm, exp);
    ofm_ready = 1'b1;
    tick();
    check_eq({tag, "_valid_drop"}, 64'(cur_ov), 64'd0);
  endtask

  task automatic run_lin(input string tag, input logic [15:0] px, input logic [15:0] kv,
                         input logic [63:0] exp);
    sel  = 1'b0;
    kval = kv;
    start_layer();
    feed(px, 0, -1);
    take(tag, exp);
    check_eq({tag, "_end"}, {62'd0, cur_end, cur_busy}, 64'b10);
  endtask

  localparam logic [63:0] Pat = 64'h2AC0_2010_1560_0AB0;

  initial begin
    int c;
    rst = 1'b1; start_l = 1'b0; start_r = 1'b0; ifm_valid = 1'b0; ifm = '0;
    ofm_ready = 1'b1; bias = '0; kval = '0; rom_pat = 1'b0; sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check_eq("rst_ofm", ofm_l, 64'd0);
    check_eq("rst_flags", {59'd0, ov_l, rdy_l, busy_l, end_l, 1'b0}, 64'd0);
    check_eq("rst_addr", 64'(addr_l), 64'd0);
    check_eq("rst_relu_ofm", ofm_r, 64'd0);

    // Unity MAC with explicit latency check.
    kval = 16'h0100;
    start_layer();
    feed(16'h0100, 0, -1);
    wait_valid(c);
    check_eq("unity_latency", 64'(c), 64'd2);
    take("unity", 64'h1200_1200_1200_1200);
    check_eq("unity_end", {62'd0, end_l, busy_l}, 64'b10);

    run_lin("sign_lin", 16'h0100, 16'hFF00, 64'hEE00_EE00_EE00_EE00);
    run_lin("sat_pos", 16'h7FFF, 16'h7FFF, 64'h7FFF_7FFF_7FFF_7FFF);
    run_lin("sat_neg", 16'h8000, 16'h7FFF, 64'h8000_8000_8000_8000);
    bias = {4{32'h0000_0080}};
    run_lin("round_up", 16'h0000, 16'h0100, 64'h0001_0001_0001_0001);
    bias = {4{32'h0000_007F}};
    run_lin("round_down", 16'h0000, 16'h0100, 64'h0000_0000_0000_0000);
    bias = '0;

    // ReLU instance: negative results clamp to zero over a three-window layer.
    sel  = 1'b1;
    kval = 16'hFF00;
    start_layer();
    for (int w = 0; w < 3; w++) begin
      feed(16'h0100, 0, -1);
      take("sign_relu", 64'd0);
      check_eq("relu_layer_end", 64'(end_r), (w == 2) ? 64'd1 : 64'd0);
    end

    // Stalls, output back-pressure and ignored start on the pattern ROM.
    rom_pat = 1'b1;
    start_layer();
    ofm_ready = 1'b0;
    feed(16'h0100, 0, -1);
    wait_valid(c);
    ifm = 16'hDEAD;
    ifm_valid = 1'b1;
    repeat (5) begin
      check_eq("hold_ofm", ofm_r, Pat);
      check_eq("hold_flags", {62'd0, ov_r, rdy_r}, 64'b10);
      tick();
    end
    ifm_valid = 1'b0;
    take("pat_w0", Pat);
    check_eq("pat_w0_flags", {62'd0, end_r, busy_r}, 64'b01);
    feed(16'h0100, 3, 5);
    check_eq("busy_after_start", 64'(busy_r), 64'd1);
    take("pat_w1", Pat);
    check_eq("pat_w1_end", 64'(end_r), 64'd0);
    feed(16'h0100, 2, -1);
    take("pat_w2", Pat);
    check_eq("pat_w2_end", {62'd0, end_r, busy_r}, 64'b10);
    rom_pat = 1'b0;

    // Reset after seven accepted taps of window 0, then a clean unity run.
    sel  = 1'b0;
    kval = 16'h0100;
    start_layer();
    for (int t = 0; t < 7; t++) push(16'h0100);
    check_eq("mid_addr", 64'(cur_addr), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_flags", {60'd0, ov_l, rdy_l, busy_l, end_l}, 64'd0);
    check_eq("midrst_addr", 64'(addr_l), 64'd0);
    run_lin("unity_after_rst", 16'h0100, 16'h0100, 64'h1200_1200_1200_1200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_mac_array.md
# conv_mac_array

Parametrised convolution MAC engine for one layer of the SqueezeNet datapath (squeeze/expand convolutions). It consumes a serialised window stream of `CHIN*KERNEL_DIM**2` pixels per output position and fetches one weight row per tap from a registered weight ROM. Across `DSP_NO` parallel lanes it accumulates, adds bias, requantises with round-to-nearest and saturation, and optionally applies ReLU. Unlike the previous fixed layers, it has valid/ready handshakes on both streams, a start/busy/end layer control, signed saturation and a configurable fixed-point shift.

## Interface
- `DSP_NO`, 16: parallel output-channel lanes.
- `WIDTH`, 16: signed pixel/weight/output width.
- `CHIN`, 64: input channels per window.
- `KERNEL_DIM`, 3: kernel side; `TAPS = CHIN*KERNEL_DIM**2`.
- `N_WINDOWS`, 4096: output positions per layer (≥1).
- `FRAC`, 8: requantisation right shift (≥1).
- `RELU_EN`, 1: 1 = clamp negative results to 0.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin layer; sampled in IDLE or DONE only.
- `ifm`  in  WIDTH  signed pixel, tap order.
- `ifm_valid`  in  1  pixel valid.
- `ifm_ready`  out  1  block accepts pixel.
- `weight_addr`  out  $clog2(TAPS)  current tap index to weight ROM.
- `kernels`  in  DSP_NO×WIDTH  signed weights; ROM is registered: data for `weight_addr` at edge n is valid after edge n.
- `bias`  in  DSP_NO×2*WIDTH  signed per-lane bias, same fixed point as product (2·FRAC frac bits); static during layer.
- `ofm`  out  DSP_NO×WIDTH  signed results.
- `ofm_valid`  out  1  results valid.
- `ofm_ready`  in  1  consumer accepts.
- `busy`  out  1  state ≠ IDLE/DONE.
- `layer_end`  out  1  all N_WINDOWS delivered.

## Operation
- States: IDLE, ACC, FLUSH, QUANT, OUT, DONE.
- IDLE: `ifm_ready`=0. On `start`, go to ACC; tap=0, win=0, accumulators=0.
- ACC: `ifm_ready`=1. `weight_addr` = tap counter (combinational from the register).
- Accept = `ifm_valid && ifm_ready`. On accept, capture `pix_d`<=ifm, set `mac_en`<=1, tap++.
- On the next edge, if `mac_en`: acc[i] += pix_d * kernels[i]. Non-accept cycles do no MAC.
- Accept of tap TAPS-1 goes to FLUSH; tap wraps to 0.
- FLUSH: `ifm_ready`=0; the final product is accumulated at this edge; go to QUANT.
- QUANT: the edge registers ofm[i] = q(acc[i]+bias[i]); `ofm_valid`<=1; go to OUT.
- OUT: hold `ofm` and `ofm_valid` stable until `ofm_ready`.
- On handshake: `ofm_valid`<=0, acc cleared, win++. If win was N_WINDOWS-1, go to DONE; otherwise go to ACC.
- DONE: `layer_end`=1 and held. `start` clears `layer_end` and restarts as from IDLE.
- Arithmetic:
  - Product is a signed 2·WIDTH-bit value.
  - Accumulator is signed, 2·WIDTH+$clog2(TAPS) bits; bias is sign-extended.
  - q(s) = (s + 2^(FRAC-1)) >>> FRAC, arithmetic shift.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If RELU_EN and the result is negative, output 0.
- `start` outside IDLE/DONE is ignored. `ifm` is ignored while `ifm_ready`=0.

## Timing
- Reset values: `ofm` all 0, `ofm_valid`=0, `ifm_ready`=0, `busy`=0, `layer_end`=0, `weight_addr`=0; state IDLE, counters and accumulators 0.
- `rst` in any state (including mid-ACC or OUT with `ofm_valid`=1) forces the reset state at the next edge.
- Latency: last tap accepted at edge n → `ofm_valid` high after edge n+2.
- Window period with no stalls and `ofm_ready`=1: TAPS+3 cycles.
- `start` in IDLE at edge n → `ifm_ready`=1 and `busy`=1 after edge n.
- `ofm_ready` already high when `ofm_valid` rises: handshake in the first OUT cycle.
- `ifm_valid` gaps stretch ACC without corrupting the tap/weight alignment.
- `layer_end` rises at the edge of the final OUT handshake; `busy` falls at the same edge.

## Test plan
Base parameters: DSP_NO=4, CHIN=2, KERNEL_DIM=3 (TAPS=18), WIDTH=16, FRAC=8, N_WINDOWS=1.

- Unity MAC: ifm=0x0100 all taps, kernels=0x0100, bias=0 → every lane ofm=0x1200, `ofm_valid` 2 cycles after the 18th accept.
- Sign and ReLU: kernels=0xFF00 (-1.0), ifm=0x0100.
  - RELU_EN=1 → ofm=0x0000.
  - RELU_EN=0 → ofm=0xEE00.
- Saturation: ifm=0x7FFF, kernels=0x7FFF → ofm=0x7FFF.
- Negative saturation: ifm=0x8000, kernels=0x7FFF, RELU_EN=0 → ofm=0x8000.
- Rounding: ifm=0.
  - bias=0x80 → ofm=0x0001.
  - bias=0x7F → ofm=0x0000.
- Stalls and end, N_WINDOWS=3:
  - Random `ifm_valid` gaps → results identical to the no-stall run.
  - `ofm_ready` low 5 cycles → `ofm` stable and `ifm_ready`=0 throughout.
  - `layer_end`=1 exactly at the third handshake.
  - `start` while busy → no effect.
- Reset mid-operation: `rst` after tap 7 of window 0 → next cycle IDLE, `ofm_valid`=0, `ifm_ready`=0. A fresh `start` with the unity stimulus → ofm=0x1200.
